// File: rtl/io_stage_pkg.sv
// io_stage_pkg: shared IO stage payload types, HI/LO pair and load alignment helper
package io_stage_pkg;
  localparam int CPU_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  typedef struct packed {
    logic [CPU_DATA_WIDTH-1:0]   program_count;
    logic [CPU_DATA_WIDTH-1:0]   alu_result;
    logic [CPU_DATA_WIDTH-1:0]   source_register_data;
    logic [REG_ADDR_WIDTH-1:0]   destination_register;
    logic                        register_write;
    logic                        result_is_from_memory;
    logic                        result_high;
    logic                        result_low;
    logic                        high_low_write;
    logic                        multiply_valid;
    logic                        divide_valid;
    logic [2*CPU_DATA_WIDTH-1:0] product;
    logic [CPU_DATA_WIDTH-1:0]   quotient;
    logic [CPU_DATA_WIDTH-1:0]   remainder;
  } EXToIOData;
  typedef struct packed {
    logic [CPU_DATA_WIDTH-1:0] program_count;
    logic                      register_file_write_enabled;
    logic [REG_ADDR_WIDTH-1:0] register_file_address;
    logic [CPU_DATA_WIDTH-1:0] final_result;
  } IOToWBData;
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] write_register;
    logic [CPU_DATA_WIDTH-1:0] write_data;
    logic                      previous_valid;
    logic [REG_ADDR_WIDTH-1:0] previous_write_register;
    logic [CPU_DATA_WIDTH-1:0] previous_write_data;
  } IOToIDBackPassData;
  typedef struct packed {
    logic [CPU_DATA_WIDTH-1:0] high;
    logic [CPU_DATA_WIDTH-1:0] low;
  } HiLoRegisters;
  function automatic logic [CPU_DATA_WIDTH-1:0] load_align(input logic [CPU_DATA_WIDTH-1:0] data, input logic [1:0] offset);
    return data >> {offset, 3'b000};
  endfunction
endpackage

// File: rtl/io_stage_hi_lo_register_file.sv
// hi_lo_register_file: HI/LO storage with independent write enables and same-cycle read
import io_stage_pkg::*;
module hi_lo_register_file (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      high_write_enable,
  input  logic [CPU_DATA_WIDTH-1:0] high_write_data,
  input  logic                      low_write_enable,
  input  logic [CPU_DATA_WIDTH-1:0] low_write_data,
  output HiLoRegisters              hi_lo
);
  logic [CPU_DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  // next HI/LO: take write data when enabled, else hold
  always_comb begin
    hi_d = high_write_enable ? high_write_data : hi_q;
    lo_d = low_write_enable ? low_write_data : lo_q;
  end
  // HI/LO registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign hi_lo = '{high: hi_q, low: lo_q};
endmodule

// File: rtl/io_stage.sv
// io_stage: memory/IO pipeline stage with HI/LO update and ID forwarding;
// IO_STAGE_DIVIDE_WAIT_EN adds divider ports and stalls until the divider completes
import io_stage_pkg::*;
module io_stage (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      ex_to_io_valid,
  input  EXToIOData                 ex_to_io_bus,
  output logic                      io_allow_in,
  input  logic                      wb_allow_in,
  output logic                      io_to_wb_valid,
  output IOToWBData                 io_to_wb_bus,
  output IOToIDBackPassData         io_to_id_back_pass,
`ifdef IO_STAGE_DIVIDE_WAIT_EN
  input  logic                      divider_done,
  input  logic [CPU_DATA_WIDTH-1:0] divider_quotient,
  input  logic [CPU_DATA_WIDTH-1:0] divider_remainder,
`endif
  input  logic [CPU_DATA_WIDTH-1:0] data_sram_read_data
);
  logic                      valid_q, valid_d, prev_valid_q, prev_valid_d;
  EXToIOData                 entry_q, entry_d;
  logic [REG_ADDR_WIDTH-1:0] prev_reg_q, prev_reg_d;
  logic [CPU_DATA_WIDTH-1:0] prev_data_q, prev_data_d;
  logic                      ready_go, fire, load, hi_we, lo_we;
  logic [CPU_DATA_WIDTH-1:0] quotient, remainder, final_result, hi_wdata, lo_wdata;
  HiLoRegisters              hi_lo;
`ifdef IO_STAGE_DIVIDE_WAIT_EN
  logic                      captured_q, captured_d, waiting;
  logic [CPU_DATA_WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  assign waiting = valid_q && entry_q.divide_valid && !captured_q;
  assign ready_go = !(waiting && !divider_done);
  assign quotient = captured_q ? quotient_q : divider_quotient;
  assign remainder = captured_q ? remainder_q : divider_remainder;
  // hold the first divider result seen while waiting; a new entry forgets it
  always_comb begin
    captured_d = load ? 1'b0 : (waiting && divider_done) ? 1'b1 : captured_q;
    quotient_d = (waiting && divider_done) ? divider_quotient : quotient_q;
    remainder_d = (waiting && divider_done) ? divider_remainder : remainder_q;
  end
  // divider capture registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      captured_q <= 1'b0;
      quotient_q <= '0;
      remainder_q <= '0;
    end else begin
      captured_q <= captured_d;
      quotient_q <= quotient_d;
      remainder_q <= remainder_d;
    end
  end
`else
  assign ready_go = 1'b1;
  assign quotient = entry_q.quotient;
  assign remainder = entry_q.remainder;
`endif
  assign io_to_wb_valid = valid_q && ready_go;
  assign io_allow_in = !valid_q || (ready_go && wb_allow_in);
  assign fire = io_to_wb_valid && wb_allow_in;
  assign load = ex_to_io_valid && io_allow_in;
  // result selection, HI/LO write data and next-state of the pipeline entry
  always_comb begin
    final_result = entry_q.result_is_from_memory ? load_align(data_sram_read_data, entry_q.alu_result[1:0]) :
                   (entry_q.result_high && !entry_q.high_low_write) ? hi_lo.high :
                   (entry_q.result_low && !entry_q.high_low_write) ? hi_lo.low : entry_q.alu_result;
    hi_we = fire && entry_q.high_low_write && (entry_q.multiply_valid || entry_q.divide_valid || entry_q.result_high);
    lo_we = fire && entry_q.high_low_write && (entry_q.multiply_valid || entry_q.divide_valid || entry_q.result_low);
    hi_wdata = entry_q.multiply_valid ? entry_q.product[63:32] : entry_q.divide_valid ? remainder : entry_q.source_register_data;
    lo_wdata = entry_q.multiply_valid ? entry_q.product[31:0] : entry_q.divide_valid ? quotient : entry_q.source_register_data;
    valid_d = load ? 1'b1 : fire ? 1'b0 : valid_q;
    entry_d = load ? ex_to_io_bus : entry_q;
    prev_valid_d = fire && entry_q.register_write;
    prev_reg_d = fire ? entry_q.destination_register : prev_reg_q;
    prev_data_d = fire ? final_result : prev_data_q;
  end
  // pipeline entry and previous-fire forwarding registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
      prev_valid_q <= 1'b0;
      prev_reg_q <= '0;
      prev_data_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
      prev_valid_q <= prev_valid_d;
      prev_reg_q <= prev_reg_d;
      prev_data_q <= prev_data_d;
    end
  end
  hi_lo_register_file u_hi_lo (
    .clock             (clock),
    .reset_n           (reset_n),
    .high_write_enable (hi_we),
    .high_write_data   (hi_wdata),
    .low_write_enable  (lo_we),
    .low_write_data    (lo_wdata),
    .hi_lo             (hi_lo)
  );
  assign io_to_wb_bus = '{program_count: entry_q.program_count,
                          register_file_write_enabled: entry_q.register_write && valid_q,
                          register_file_address: entry_q.destination_register,
                          final_result: final_result};
  assign io_to_id_back_pass = '{valid: valid_q && entry_q.register_write,
                                write_register: entry_q.destination_register,
                                write_data: final_result,
                                previous_valid: prev_valid_q,
                                previous_write_register: prev_reg_q,
                                previous_write_data: prev_data_q};
endmodule

// File: tb/tb_io_stage.sv
// tb_io_stage: vector table, directed corner sequences and randomized model check for io_stage
import io_stage_pkg::*;
module tb_io_stage;
  logic clock = 1'b0, reset_n = 1'b0, ex_to_io_valid = 1'b0, wb_allow_in = 1'b1;
  logic io_allow_in, io_to_wb_valid;
  EXToIOData ex_to_io_bus = '0;
  IOToWBData io_to_wb_bus;
  IOToIDBackPassData io_to_id_back_pass;
  logic [31:0] data_sram_read_data = '0;
`ifdef IO_STAGE_DIVIDE_WAIT_EN
  logic divider_done = 1'b0;
  logic [31:0] divider_quotient = '0, divider_remainder = '0;
`endif
  int tests = 0, fails = 0;

  io_stage dut (
    .clock(clock), .reset_n(reset_n), .ex_to_io_valid(ex_to_io_valid), .ex_to_io_bus(ex_to_io_bus),
    .io_allow_in(io_allow_in), .wb_allow_in(wb_allow_in), .io_to_wb_valid(io_to_wb_valid),
    .io_to_wb_bus(io_to_wb_bus), .io_to_id_back_pass(io_to_id_back_pass),
`ifdef IO_STAGE_DIVIDE_WAIT_EN
    .divider_done(divider_done), .divider_quotient(divider_quotient), .divider_remainder(divider_remainder),
`endif
    .data_sram_read_data(data_sram_read_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic EXToIOData ins(input logic [31:0] alu, input logic [31:0] src, input logic [4:0] rd,
                                    input logic rw, input logic mem, input logic hi, input logic lo,
                                    input logic hlw, input logic mul, input logic dv);
    EXToIOData b;
    b = '0;
    b.program_count = 32'hBFC0_0000 + {rd, 2'b00};
    b.alu_result = alu;
    b.source_register_data = src;
    b.destination_register = rd;
    b.register_write = rw;
    b.result_is_from_memory = mem;
    b.result_high = hi;
    b.result_low = lo;
    b.high_low_write = hlw;
    b.multiply_valid = mul;
    b.divide_valid = dv;
    return b;
  endfunction

  function automatic logic [31:0] model_result(input EXToIOData e, input logic [31:0] rd_data,
                                               input logic [31:0] hi, input logic [31:0] lo);
    if (e.result_is_from_memory) return rd_data / (32'd1 << (8 * int'(e.alu_result[1:0])));
    if (e.high_low_write) return e.alu_result;
    if (e.result_high) return hi;
    if (e.result_low) return lo;
    return e.alu_result;
  endfunction

  typedef struct {
    EXToIOData   bus;
    logic [31:0] rdata;
    logic [31:0] exp_result;
    logic        exp_we;
  } vec_t;

  vec_t vecs[6];
  EXToIOData b;
  EXToIOData m_entry;
  logic m_valid, fire_n, load_n;
  logic [31:0] m_hi, m_lo;

  initial begin
    vecs[0] = '{ins(32'h1234_5678, 32'h0, 5'd1, 1, 0, 0, 0, 0, 0, 0), 32'h0, 32'h1234_5678, 1'b1};
    vecs[1] = '{ins(32'h0000_1002, 32'h0, 5'd2, 1, 1, 0, 0, 0, 0, 0), 32'hAABB_CCDD, 32'h0000_AABB, 1'b1};
    vecs[2] = '{ins(32'h0000_1000, 32'h0, 5'd3, 1, 1, 0, 0, 0, 0, 0), 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b1};
    vecs[3] = '{ins(32'h0000_1003, 32'h0, 5'd4, 0, 1, 0, 0, 0, 0, 0), 32'h8899_0011, 32'h0000_0088, 1'b0};
    vecs[4] = '{ins(32'hDEAD_BEEF, 32'h0, 5'd5, 1, 0, 1, 0, 0, 0, 0), 32'h0, 32'h0, 1'b1};
    vecs[5] = '{ins(32'hCAFE_F00D, 32'h0, 5'd6, 1, 0, 0, 0, 0, 0, 0), 32'h0, 32'hCAFE_F00D, 1'b1};

    #3;
    chk("reset_wb_valid", io_to_wb_valid, 0);
    chk("reset_allow_in", io_allow_in, 1);
    chk("reset_bp_valid", io_to_id_back_pass.valid, 0);
    chk("reset_bp_prev_valid", io_to_id_back_pass.previous_valid, 0);
    #9 reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      ex_to_io_bus = vecs[i].bus;
      ex_to_io_valid = 1'b1;
      tick();
      data_sram_read_data = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_wb_valid", i), io_to_wb_valid, 1);
      chk($sformatf("vec%0d_allow_in", i), io_allow_in, 1);
      chk($sformatf("vec%0d_result", i), io_to_wb_bus.final_result, vecs[i].exp_result);
      chk($sformatf("vec%0d_we", i), io_to_wb_bus.register_file_write_enabled, vecs[i].exp_we);
      chk($sformatf("vec%0d_addr", i), io_to_wb_bus.register_file_address, vecs[i].bus.destination_register);
      if (i > 0) begin
        chk($sformatf("vec%0d_prev_valid", i), io_to_id_back_pass.previous_valid, vecs[i-1].exp_we);
        chk($sformatf("vec%0d_prev_data", i), io_to_id_back_pass.previous_write_data, vecs[i-1].exp_result);
      end
    end
    ex_to_io_valid = 1'b0;
    tick();

    b = ins(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 1, 0);
    b.product = 64'h0000_0001_FFFF_FFFE;
    ex_to_io_bus = b;
    ex_to_io_valid = 1'b1;
    tick();
    ex_to_io_bus = ins(32'h0, 32'h0, 5'd7, 1, 0, 1, 0, 0, 0, 0);
    tick();
    chk("mfhi_no_bubble", io_to_wb_valid, 1);
    chk("mfhi_result", io_to_wb_bus.final_result, 32'h0000_0001);
    ex_to_io_bus = ins(32'h0, 32'h0, 5'd8, 1, 0, 0, 1, 0, 0, 0);
    tick();
    chk("mflo_result", io_to_wb_bus.final_result, 32'hFFFF_FFFE);
    ex_to_io_valid = 1'b0;
    tick();

    wb_allow_in = 1'b0;
    ex_to_io_bus = ins(32'h5555_AAAA, 32'h0, 5'd9, 1, 0, 0, 0, 0, 0, 0);
    ex_to_io_valid = 1'b1;
    tick();
    ex_to_io_bus = ins(32'h0F0F_0F0F, 32'h0, 5'd10, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      chk("stall_allow_in", io_allow_in, 0);
      chk("stall_wb_valid", io_to_wb_valid, 1);
      chk("stall_result", io_to_wb_bus.final_result, 32'h5555_AAAA);
      chk("stall_addr", io_to_wb_bus.register_file_address, 9);
      tick();
    end
    wb_allow_in = 1'b1;
    tick();
    chk("fire_load_valid", io_to_wb_valid, 1);
    chk("fire_load_result", io_to_wb_bus.final_result, 32'h0F0F_0F0F);
    ex_to_io_valid = 1'b0;
    tick();

    b = ins(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 0, 1);
`ifdef IO_STAGE_DIVIDE_WAIT_EN
    ex_to_io_bus = b;
    ex_to_io_valid = 1'b1;
    tick();
    ex_to_io_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("div_wait_wb_valid", io_to_wb_valid, 0);
      chk("div_wait_allow_in", io_allow_in, 0);
      tick();
    end
    wb_allow_in = 1'b0;
    divider_done = 1'b1;
    divider_quotient = 32'd7;
    divider_remainder = 32'd3;
    #1 chk("div_done_wb_valid", io_to_wb_valid, 1);
    tick();
    divider_done = 1'b0;
    divider_quotient = 32'd99;
    divider_remainder = 32'd98;
    #1 chk("div_captured_wb_valid", io_to_wb_valid, 1);
    wb_allow_in = 1'b1;
    tick();
`else
    b.quotient = 32'd7;
    b.remainder = 32'd3;
    ex_to_io_bus = b;
    ex_to_io_valid = 1'b1;
    tick();
    chk("div_wb_valid", io_to_wb_valid, 1);
`endif
    ex_to_io_bus = ins(32'h0, 32'h0, 5'd11, 1, 0, 0, 1, 0, 0, 0);
    ex_to_io_valid = 1'b1;
    tick();
    chk("div_lo", io_to_wb_bus.final_result, 32'd7);
    ex_to_io_bus = ins(32'h0, 32'h0, 5'd12, 1, 0, 1, 0, 0, 0, 0);
    tick();
    chk("div_hi", io_to_wb_bus.final_result, 32'd3);
    ex_to_io_valid = 1'b0;
    tick();

    wb_allow_in = 1'b0;
    ex_to_io_bus = ins(32'h0, 32'h0, 5'd13, 1, 0, 0, 0, 1, 0, 1);
    ex_to_io_valid = 1'b1;
    tick();
    ex_to_io_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_wb_valid", io_to_wb_valid, 0);
    chk("rst_mid_allow_in", io_allow_in, 1);
    chk("rst_mid_bp_valid", io_to_id_back_pass.valid, 0);
    #3 reset_n = 1'b1;
    tick();
    wb_allow_in = 1'b1;
    ex_to_io_bus = ins(32'h0, 32'h0, 5'd14, 1, 0, 1, 0, 0, 0, 0);
    ex_to_io_valid = 1'b1;
    tick();
    chk("rst_hi_cleared", io_to_wb_bus.final_result, 0);
    ex_to_io_bus = ins(32'h0, 32'h0, 5'd15, 1, 0, 0, 1, 0, 0, 0);
    tick();
    chk("rst_lo_cleared", io_to_wb_bus.final_result, 0);
    ex_to_io_valid = 1'b0;
    tick();

    m_valid = 1'b0;
    m_hi = '0;
    m_lo = '0;
    m_entry = '0;
    for (int n = 0; n < 400; n++) begin
      int kind;
`ifdef IO_STAGE_DIVIDE_WAIT_EN
      kind = $urandom_range(0, 5);
      if (kind == 3) kind = 0;
`else
      kind = $urandom_range(0, 6);
`endif
      b = ins($urandom, $urandom, 5'($urandom), 1'($urandom), kind == 1, kind == 4 || kind == 6, kind == 5 || kind == 0,
              kind inside {2, 3, 4, 5}, kind == 2, kind == 3);
      if (kind == 6 && $urandom_range(0, 1) == 1) begin
        b.result_high = 1'b0;
        b.result_low = 1'b1;
      end
      if (kind == 0) b.result_low = 1'b0;
      b.product = {$urandom, $urandom};
      b.quotient = $urandom;
      b.remainder = $urandom;
      ex_to_io_bus = b;
      ex_to_io_valid = 1'($urandom);
      wb_allow_in = $urandom_range(0, 3) != 0;
      data_sram_read_data = $urandom;
      #3;
      chk("rnd_wb_valid", io_to_wb_valid, m_valid);
      chk("rnd_allow_in", io_allow_in, !m_valid || wb_allow_in);
      if (m_valid) begin
        chk("rnd_result", io_to_wb_bus.final_result, model_result(m_entry, data_sram_read_data, m_hi, m_lo));
        chk("rnd_we", io_to_wb_bus.register_file_write_enabled, m_entry.register_write);
        chk("rnd_pc", io_to_wb_bus.program_count, m_entry.program_count);
      end
      fire_n = m_valid && wb_allow_in;
      load_n = ex_to_io_valid && (!m_valid || wb_allow_in);
      if (fire_n && m_entry.high_low_write) begin
        if (m_entry.multiply_valid) {m_hi, m_lo} = m_entry.product;
        else if (m_entry.divide_valid) {m_hi, m_lo} = {m_entry.remainder, m_entry.quotient};
        else begin
          if (m_entry.result_high) m_hi = m_entry.source_register_data;
          if (m_entry.result_low) m_lo = m_entry.source_register_data;
        end
      end
      if (load_n) m_entry = ex_to_io_bus;
      m_valid = load_n || (m_valid && !fire_n);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
